cv32e40p_hwloop_shuffler: RTL and testbench
===========================================

# cv32e40p_hwloop_shuffler

Parametrised successor to the hardware-loop index permuter. It generates a uniformly distributed random permutation of `0..NUM_INPUT-1` with a sequential Fisher-Yates shuffle driven by an external random source through a valid/ready handshake. It holds the last committed permutation stable on `index_o` for the hwloop iteration-reorder logic. It supports any power-of-two `NUM_INPUT`, a single queued request, and an identity bypass mode.

## Interface
Parameters:
- `NUM_INPUT`, default 4: number of indices; a power of two, 2..16.
- `INPUT_WIDTH`, default `$clog2(NUM_INPUT)`: index width. Any other value is illegal.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `next_i`  in  1  request a new permutation; level sampled each cycle.
- `bypass_i`  in  1  sampled when a request is accepted; 1 means commit the identity permutation without shuffling.
- `rnd_valid_i`  in  1  random word available.
- `rnd_i`  in  INPUT_WIDTH  random word.
- `rnd_ready_o`  out  1  shuffler consumes `rnd_i` this cycle if `rnd_valid_i` is high.
- `busy_o`  out  1  a shuffle is in progress.
- `done_o`  out  1  one-cycle pulse; `index_o` took a new value this cycle.
- `index_o`  out  [NUM_INPUT-1:0][INPUT_WIDTH-1:0]  committed permutation, registered.

## Operation
- State registers: FSM state (`IDLE`, `SHUFFLE`), work array `work_q[NUM_INPUT]`, position counter `k_q` (INPUT_WIDTH bits), `pending_q`, output array `index_q`, `done_q`.
- **`IDLE`**:
  - `next_i` with `bypass_i=0`: load `work_q[i]<=i`, load `k_q<=NUM_INPUT-1`, go to `SHUFFLE`.
  - `next_i` with `bypass_i=1`: load `index_q[i]<=i`, set `done_q<=1`, stay in `IDLE`.
- **`SHUFFLE`**:
  - `rnd_ready_o=1`. A handshake is `rnd_valid_i && rnd_ready_o`.
  - Masked value: `r = rnd_i & mask(k_q)`, where `mask(k)` is the smallest `2^m-1` that is `>= k`.
  - On a handshake with `r <= k_q`: swap `work_q[k_q]` and `work_q[r]`. If `r == k_q`, there is no change.
  - On a handshake with `r > k_q`: reject. The word is consumed, and `work_q` and `k_q` are unchanged. This rejection makes the result unbiased.
  - After an accepted word with `k_q > 1`: `k_q<=k_q-1`.
  - After an accepted word with `k_q == 1`: write the post-swap array directly into `index_q`, set `done_q<=1`, and go to `IDLE`.
- **Queued request**:
  - `next_i` while `busy_o=1` sets `pending_q`. Further requests while it is set are merged, so at most one request is queued.
  - On completion with `pending_q=1`: clear `pending_q`, reload `work_q` and `k_q`, and stay in `SHUFFLE`.
  - `bypass_i` is sampled at that restart edge.
  - `next_i` in the completion cycle itself counts as a queued request.
- Output signals:
  - `busy_o = (state==SHUFFLE)`.
  - `done_o = done_q`; `done_q` clears on the next cycle unless it is set again.
- `index_o` changes only on commit and is otherwise held indefinitely.

## Timing
- **Reset** (asynchronous, `rst_n=0`): `index_q[i]=i`, `done_o=0`, `busy_o=0`, `rnd_ready_o=0`, `pending_q=0`, state `IDLE`. Reset mid-shuffle discards the partial work and any pending request.
- **Shuffle latency**:
  - `next_i` high at edge t gives `busy_o=1` from t+1.
  - With `rnd_valid_i` held high and no rejections, the handshakes occur in the `NUM_INPUT-1` cycles starting at t+1.
  - New `index_o` and `done_o=1` appear in cycle t+`NUM_INPUT`.
  - Each rejection adds one cycle. A stalled random source (`rnd_valid_i=0`) adds cycles without limit.
- **Bypass latency**: new `index_o` and `done_o=1` in cycle t+1.
- **Back-to-back with a pending request**: no idle cycle. `busy_o` stays high, and `done_o` pulses on the intermediate commit.
- **Consumption rule**: `rnd_i` is consumed only on a handshake, never in `IDLE`.

## Test plan
- **Reset**: assert `rst_n=0` asynchronously mid-cycle -> `index_o` becomes `{3,2,1,0}` (element 3..0) immediately, `busy_o=0`, `done_o=0`.
- **Shuffle with one rejection**: `NUM_INPUT=4`, `rnd_valid_i=1`, `rnd_i` sequence 0,3,1,0.
  - After the first word: `work={3,1,2,0}` (elements 0..3).
  - The second word (3 > 2) is rejected.
  - Final `index_o[0..3]={2,3,1,0}`; `done_o` pulses 5 cycles after the request edge.
- **Bypass**: after a shuffle, request with `bypass_i=1` -> `index_o[i]=i` next cycle, one `done_o` pulse, `rnd_ready_o` never high.
- **Queued requests**: pulse `next_i` three times during a shuffle -> exactly two `done_o` pulses total, `busy_o` continuous between them.
- **Stall and reset**: `rnd_valid_i=0` for 10 cycles mid-shuffle -> `busy_o` held, `index_o` unchanged. Then `rst_n` low -> identity output and `IDLE`.
- **Statistics**: `NUM_INPUT=8` with an LFSR random source, 8000 shuffles.
  - Every output is a valid permutation (no duplicates).
  - Each index lands in each position 1000±150 times.

Source files
------------

// File: rtl/cv32e40p_hwloop_shuffler.sv
// cv32e40p_hwloop_shuffler
// Produces a random permutation of 0..NUM_INPUT-1 using a sequential
// Fisher-Yates shuffle. Random words come in through a valid/ready handshake.
// The last committed permutation is held on index_o until the next commit.
// A single request can be queued while a shuffle runs. An identity bypass
// commits 0..N-1 without consuming any random words.
module cv32e40p_hwloop_shuffler #(
    parameter int NUM_INPUT   = 4,
    parameter int INPUT_WIDTH = $clog2(NUM_INPUT)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      next_i,
    input  logic                                      bypass_i,
    input  logic                                      rnd_valid_i,
    input  logic [INPUT_WIDTH-1:0]                    rnd_i,
    output logic                                      rnd_ready_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [NUM_INPUT-1:0][INPUT_WIDTH-1:0]     index_o
);

    typedef enum logic {
        IDLE,
        SHUFFLE
    } state_e;

    state_e                                 state_q;
    logic [NUM_INPUT-1:0][INPUT_WIDTH-1:0]  work_q;
    logic [NUM_INPUT-1:0][INPUT_WIDTH-1:0]  index_q;
    logic [NUM_INPUT-1:0][INPUT_WIDTH-1:0]  identity;
    logic [NUM_INPUT-1:0][INPUT_WIDTH-1:0]  swapped;
    logic [INPUT_WIDTH-1:0]                 k_q;
    logic [INPUT_WIDTH-1:0]                 mask;
    logic [INPUT_WIDTH-1:0]                 r;
    logic                                   pending_q;
    logic                                   done_q;
    logic                                   handshake;
    logic                                   accept;
    logic                                   last_step;
    logic                                   restart;

    // Identity permutation used for reset, bypass and work array reload.
    always_comb begin
        identity = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            identity[i] = INPUT_WIDTH'(i);
        end
    end

    // Smallest all-ones mask covering k. Masking the random word this way
    // keeps rejections rare while the r > k rejection keeps the draw uniform.
    always_comb begin
        mask = k_q;
        for (int s = 1; s < INPUT_WIDTH; s++) begin
            mask = mask | (mask >> s);
        end
    end

    assign r         = rnd_i & mask;
    assign handshake = rnd_valid_i && (state_q == SHUFFLE);
    assign accept    = handshake && (r <= k_q);
    assign last_step = (k_q <= INPUT_WIDTH'(1));
    assign restart   = pending_q || next_i;

    // Work array with positions k and r exchanged. When r == k this is a no-op.
    always_comb begin
        swapped      = work_q;
        swapped[k_q] = work_q[r];
        swapped[r]   = work_q[k_q];
    end

    // Control FSM, shuffle datapath, request queue and committed output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= identity;
            index_q   <= identity;
            k_q       <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (next_i || pending_q) begin
                        pending_q <= 1'b0;
                        if (bypass_i) begin
                            index_q <= identity;
                            done_q  <= 1'b1;
                        end else begin
                            work_q  <= identity;
                            k_q     <= INPUT_WIDTH'(NUM_INPUT - 1);
                            state_q <= SHUFFLE;
                        end
                    end
                end
                SHUFFLE: begin
                    if (next_i) begin
                        pending_q <= 1'b1;
                    end
                    if (accept) begin
                        if (!last_step) begin
                            work_q <= swapped;
                            k_q    <= k_q - INPUT_WIDTH'(1);
                        end else begin
                            index_q <= swapped;
                            done_q  <= 1'b1;
                            if (restart && !bypass_i) begin
                                pending_q <= 1'b0;
                                work_q    <= identity;
                                k_q       <= INPUT_WIDTH'(NUM_INPUT - 1);
                            end else if (restart) begin
                                // A queued bypass is served from IDLE on the next cycle.
                                pending_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rnd_ready_o = (state_q == SHUFFLE);
    assign busy_o      = (state_q == SHUFFLE);
    assign done_o      = done_q;
    assign index_o     = index_q;

endmodule

// File: tb/tb_cv32e40p_hwloop_shuffler.sv
// Testbench for cv32e40p_hwloop_shuffler.
// Directed checks run on a 4-entry instance. A statistics run uses an 8-entry
// instance fed by an LFSR.
module tb_cv32e40p_hwloop_shuffler;

    logic             clk;
    logic             rst_n;

    logic             next;
    logic             bypass;
    logic             rndValid;
    logic [1:0]       rnd;
    logic             rndReady;
    logic             busy;
    logic             done;
    logic [3:0][1:0]  index;

    logic             next8;
    logic             bypass8;
    logic             rndValid8;
    logic [2:0]       rnd8;
    logic             rndReady8;
    logic             busy8;
    logic             done8;
    logic [7:0][2:0]  index8;

    int totalChecks;
    int badChecks;

    localparam logic [7:0] IDENT4 = 8'hE4;

    cv32e40p_hwloop_shuffler #(.NUM_INPUT(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_i      (next),
        .bypass_i    (bypass),
        .rnd_valid_i (rndValid),
        .rnd_i       (rnd),
        .rnd_ready_o (rndReady),
        .busy_o      (busy),
        .done_o      (done),
        .index_o     (index)
    );

    cv32e40p_hwloop_shuffler #(.NUM_INPUT(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_i      (next8),
        .bypass_i    (bypass8),
        .rnd_valid_i (rndValid8),
        .rnd_i       (rnd8),
        .rnd_ready_o (rndReady8),
        .busy_o      (busy8),
        .done_o      (done8),
        .index_o     (index8)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the 4-entry instance, let one rising edge pass, return 1 time unit later.
    task automatic applyStimulus(input logic nxt, input logic byp, input logic vld,
                                 input logic [1:0] word);
        next     = nxt;
        bypass   = byp;
        rndValid = vld;
        rnd      = word;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
        end
        return v;
    endfunction

    // Directed sequence followed by the statistics run.
    initial begin
        logic [1:0]  seq [4];
        int          doneAt;
        int          dones;
        int          drops;
        int          rdyHigh;
        int          stallBad;
        int          changed;
        int          c;
        int          shuffles;
        int          permBad;
        int          hist [8][8];
        logic [7:0]  seen;
        logic [31:0] lfsr;

        totalChecks = 0;
        badChecks   = 0;
        rst_n    = 1'b0;
        next     = 1'b0;
        bypass   = 1'b0;
        rndValid = 1'b0;
        rnd      = 2'd0;
        next8     = 1'b0;
        bypass8   = 1'b0;
        rndValid8 = 1'b0;
        rnd8      = 3'd0;

        // Reset state.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
        checkOutput("rst_index", 32'(index), 32'(IDENT4));
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ready", 32'(rndReady), 32'd0);
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Shuffle with one rejection: words 0,3,1,0 give {2,3,1,0}.
        seq[0] = 2'd0; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
        checkOutput("shuf_busy", 32'(busy), 32'd1);
        checkOutput("shuf_ready", 32'(rndReady), 32'd1);
        doneAt  = 0;
        changed = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (k <= 4) ? seq[k-1] : 2'd0);
            if (done) begin
                doneAt = k;
                break;
            end
            if (index != IDENT4) changed++;
        end
        checkOutput("shuf_latency", 32'(doneAt), 32'd4);
        checkOutput("shuf_hold", 32'(changed), 32'd0);
        checkOutput("shuf_index", 32'(index), 32'h1E);
        checkOutput("shuf_busy_end", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        checkOutput("shuf_done_clr", 32'(done), 32'd0);
        checkOutput("shuf_index_hold", 32'(index), 32'h1E);
        checkOutput("shuf_ready_idle", 32'(rndReady), 32'd0);

        // Bypass commits identity on the next cycle without touching the source.
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3);
        checkOutput("byp_index", 32'(index), 32'(IDENT4));
        checkOutput("byp_done", 32'(done), 32'd1);
        dones   = 1;
        rdyHigh = (rndReady || busy) ? 1 : 0;
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
            if (done) dones++;
            if (rndReady) rdyHigh++;
        end
        checkOutput("byp_pulses", 32'(dones), 32'd1);
        checkOutput("byp_ready", 32'(rdyHigh), 32'd0);

        // Three requests during a shuffle merge into one queued request.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        dones = 0;
        drops = 0;
        c     = 0;
        while (dones < 2 && c < 40) begin
            c++;
            applyStimulus((c <= 6) && (c % 2 == 1), 1'b0, (c > 6) || (c % 2 == 0), 2'd0);
            if (done) dones++;
            if (dones < 2 && !busy) drops++;
        end
        checkOutput("queue_pulses", 32'(dones), 32'd2);
        checkOutput("queue_busy_gap", 32'(drops), 32'd0);
        checkOutput("queue_cycles", 32'(c), 32'd9);
        checkOutput("queue_index", 32'(index), 32'h39);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        checkOutput("queue_no_third", 32'(done), 32'd0);
        checkOutput("queue_idle", 32'(busy), 32'd0);

        // A stalled source holds the shuffle, then reset clears it mid-cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        stallBad = 0;
        repeat (10) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
            if (!busy || !rndReady || done || index != 8'h39) stallBad++;
        end
        checkOutput("stall_hold", 32'(stallBad), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_index", 32'(index), 32'(IDENT4));
        checkOutput("areset_busy", 32'(busy), 32'd0);
        checkOutput("areset_done", 32'(done), 32'd0);
        checkOutput("areset_ready", 32'(rndReady), 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_index", 32'(index), 32'(IDENT4));

        // Statistics: 8000 back-to-back shuffles on the 8-entry instance.
        for (int p = 0; p < 8; p++) begin
            for (int v = 0; v < 8; v++) hist[p][v] = 0;
        end
        shuffles  = 0;
        permBad   = 0;
        lfsr      = 32'h1234_5678;
        next8     = 1'b1;
        rndValid8 = 1'b1;
        for (int cyc = 0; cyc < 95000 && shuffles < 8000; cyc++) begin
            lfsr = lfsrStep(lfsr);
            rnd8 = lfsr[2:0];
            @(posedge clk);
            #1;
            if (done8) begin
                shuffles++;
                seen = '0;
                for (int p = 0; p < 8; p++) begin
                    seen[index8[p]] = 1'b1;
                    hist[p][index8[p]]++;
                end
                if (seen != 8'hFF) permBad++;
            end
        end
        next8     = 1'b0;
        rndValid8 = 1'b0;
        checkOutput("stat_count", 32'(shuffles), 32'd8000);
        checkOutput("stat_perm_bad", 32'(permBad), 32'd0);
        for (int p = 0; p < 8; p++) begin
            for (int v = 0; v < 8; v++) begin
                checkOutput($sformatf("stat_p%0d_v%0d", p, v),
                            32'((hist[p][v] >= 850) && (hist[p][v] <= 1150)), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
